// File: rtl/vga_sync_to_count_pkg.sv
// Shared VGA timing constants and lock FSM encoding for the sync generator and sync-to-count receiver.
package vga_sync_to_count_pkg;

   localparam int VGA_TOTAL_COLS  = 800;
   localparam int VGA_TOTAL_ROWS  = 525;
   localparam int VGA_ACTIVE_COLS = 640;
   localparam int VGA_ACTIVE_ROWS = 480;
   localparam int CNT_W           = 10;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } sync_state_e;

endpackage

// File: rtl/vga_sync_to_count_sync_edge_detect.sv
// Rising-edge detector for one sync line; the history flop resets high so a sync
// already asserted when reset releases is not taken as an edge.
module sync_edge_detect
   import vga_sync_to_count_pkg::*;
(
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Sync,
   output logic o_Rise
);

   logic prev_q, prev_d;

   always_comb begin
      prev_d = i_Sync;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) prev_q <= 1'b1;
      else         prev_q <= prev_d;
   end

   assign o_Rise = i_Sync & ~prev_q;

endmodule

// File: rtl/vga_sync_to_count.sv
// Regenerates column/row counts from an incoming active-high HSync/VSync stream,
// checks its timing against the configured totals and reports lock.
module vga_sync_to_count
   import vga_sync_to_count_pkg::*;
#(
   parameter int TOTAL_COLS  = VGA_TOTAL_COLS,
   parameter int TOTAL_ROWS  = VGA_TOTAL_ROWS,
   parameter int ACTIVE_COLS = VGA_ACTIVE_COLS,
   parameter int ACTIVE_ROWS = VGA_ACTIVE_ROWS,
   parameter int LOCK_FRAMES = 2
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_HSync,
   input  logic             i_VSync,
   output logic             o_HSync,
   output logic             o_VSync,
   output logic [CNT_W-1:0] o_Col_Count,
   output logic [CNT_W-1:0] o_Row_Count,
   output logic             o_Locked,
   output logic             o_Sync_Err
);

   if (TOTAL_COLS < 2 || TOTAL_COLS > 1024 || TOTAL_ROWS < 2 || TOTAL_ROWS > 1024 ||
       ACTIVE_COLS >= TOTAL_COLS || ACTIVE_ROWS >= TOTAL_ROWS || LOCK_FRAMES < 1) begin : g_bad_cfg
      $error("vga_sync_to_count: invalid timing parameters");
   end

   localparam int GW = $clog2(LOCK_FRAMES + 1);
   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

   logic             hs_rise, vs_rise;
   logic             hs_q, hs_d, vs_q, vs_d;
   logic             aligned_q, aligned_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
   logic [GW-1:0]    good_q, good_d;
   sync_state_e      state_q, state_d;
   logic             line_end, frame_end, err;

   sync_edge_detect u_hs_edge (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Sync  (i_HSync),
      .o_Rise  (hs_rise)
   );

   sync_edge_detect u_vs_edge (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Sync  (i_VSync),
      .o_Rise  (vs_rise)
   );

   assign line_end  = (col_q == COL_LAST);
   assign frame_end = line_end & (row_q == ROW_LAST);
   assign err       = (hs_rise ^ line_end) | (vs_rise ^ frame_end);

   // Counters hold at zero until the first frame start after reset, so a
   // mid-frame reset release never produces counts for an unknown position.
   always_comb begin
      hs_d      = i_HSync;
      vs_d      = i_VSync;
      aligned_d = aligned_q | vs_rise;
      col_d     = col_q;
      row_d     = row_q;
      if (vs_rise) begin
         col_d = '0;
         row_d = '0;
      end else if (aligned_q) begin
         if (line_end) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + CNT_W'(1);
         end else begin
            col_d = col_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      err_d   = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            if (vs_rise) begin
               state_d = ST_VERIFY;
               good_d  = '0;
            end
         end
         ST_VERIFY, ST_LOCKED: begin
            if (err) begin
               err_d   = 1'b1;
               good_d  = '0;
               state_d = vs_rise ? ST_VERIFY : ST_SEARCH;
            end else if (vs_rise && state_q == ST_VERIFY) begin
               good_d = good_q + GW'(1);
               if (int'(good_q) + 1 == LOCK_FRAMES) state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_SEARCH;
            good_d  = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
         aligned_q <= 1'b0;
         err_q     <= 1'b0;
         col_q     <= '0;
         row_q     <= '0;
         good_q    <= '0;
         state_q   <= ST_SEARCH;
      end else begin
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         aligned_q <= aligned_d;
         err_q     <= err_d;
         col_q     <= col_d;
         row_q     <= row_d;
         good_q    <= good_d;
         state_q   <= state_d;
      end
   end

   assign o_HSync     = hs_q;
   assign o_VSync     = vs_q;
   assign o_Col_Count = col_q;
   assign o_Row_Count = row_q;
   assign o_Locked    = (state_q == ST_LOCKED);
   assign o_Sync_Err  = err_q;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Scoreboard bench: a 10x6 sync source with directed faults; expected outputs are queued per cycle.
module tb_vga_sync_to_count;
   import vga_sync_to_count_pkg::*;

   localparam int TC = 10, TR = 6, AC = 8, AR = 4, LF = 2;
   localparam int LAST_W = 1047;

   logic             clk = 1'b0;
   logic             rst, hs, vs;
   logic             hs_o, vs_o, locked_o, err_o;
   logic [CNT_W-1:0] col_o, row_o;

   typedef struct {
      int         due;
      logic       care_cnt;
      logic       hs;
      logic       vs;
      logic       locked;
      logic       err;
      logic [9:0] col;
      logic [9:0] row;
   } exp_t;

   exp_t q[$];
   exp_t e;
   exp_t m;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   gc, gr, ncols;
   logic r, h, v;

   vga_sync_to_count #(
      .TOTAL_COLS  (TC),
      .TOTAL_ROWS  (TR),
      .ACTIVE_COLS (AC),
      .ACTIVE_ROWS (AR),
      .LOCK_FRAMES (LF)
   ) dut (
      .i_Clk       (clk),
      .i_Reset     (rst),
      .i_HSync     (hs),
      .i_VSync     (vs),
      .o_HSync     (hs_o),
      .o_VSync     (vs_o),
      .o_Col_Count (col_o),
      .o_Row_Count (row_o),
      .o_Locked    (locked_o),
      .o_Sync_Err  (err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int want);
      n_tests++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, want);
      end
   endtask

   task automatic drive(input logic rr, input logic hh, input logic vv, input exp_t ee);
      exp_t t;
      @(posedge clk);
      #1;
      rst = rr;
      hs  = hh;
      vs  = vv;
      t = ee;
      t.due = cyc + 1;
      q.push_back(t);
   endtask

   function automatic logic in_lock(input int w);
      return (w >= 120 && w <= 199) || (w >= 360 && w <= 439) || (w >= 603 && w <= 677);
   endfunction

   function automatic logic in_err(input int w);
      return w == 200 || w == 440 || w == 793 || w == 859 || w == 925 || w == 991;
   endfunction

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (q.size() > 0 && q[0].due <= cyc) begin
            m = q.pop_front();
            chk("due_cycle", m.due, cyc);
            chk("hsync",    int'(hs_o),     int'(m.hs));
            chk("vsync",    int'(vs_o),     int'(m.vs));
            chk("locked",   int'(locked_o), int'(m.locked));
            chk("sync_err", int'(err_o),    int'(m.err));
            if (m.care_cnt) begin
               chk("col", int'(col_o), int'(m.col));
               chk("row", int'(row_o), int'(m.row));
            end
         end
      end
   end

   initial begin : driver
      rst = 1'b1;
      hs  = 1'b0;
      vs  = 1'b0;
      e.due = 0; e.care_cnt = 1'b1; e.hs = 1'b0; e.vs = 1'b0;
      e.locked = 1'b0; e.err = 1'b0; e.col = '0; e.row = '0;
      // Two reset cycles, then one idle cycle so the edge detectors see low syncs.
      drive(1'b1, 1'b0, 1'b0, e);
      drive(1'b1, 1'b0, 1'b0, e);
      drive(1'b0, 1'b0, 1'b0, e);

      gc = 0; gr = 0; ncols = TC;
      for (int w = 0; w <= LAST_W; w++) begin
         if (w == 783) ncols = 11;
         h = (gc < AC);
         v = (gr < AR);
         if (w >= 200 && w <= 207) h = 1'b0;
         r = (w == 678);

         e.hs     = r ? 1'b0 : h;
         e.vs     = r ? 1'b0 : v;
         e.locked = in_lock(w);
         e.err    = in_err(w);
         if (r || (w >= 679 && w <= 722)) begin
            e.care_cnt = 1'b1;
            e.col = '0;
            e.row = '0;
         end else begin
            e.care_cnt = (w <= 434) || (w >= 483 && w <= 792);
            e.col = 10'(gc);
            e.row = 10'(gr);
         end
         drive(r, h, v, e);

         // Source stalls three cycles at (5,1) to shift its timing by +3.
         if (!(w >= 435 && w <= 437)) begin
            if (gc == ncols - 1) begin
               gc = 0;
               gr = (gr == TR - 1) ? 0 : gr + 1;
            end else begin
               gc++;
            end
         end
      end

      repeat (3) @(posedge clk);
      chk("drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
